// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - synchronize, debounce and latch loop-detector demand requests
// Three identical channels (0 = NN, 1 = NS, 2 = TH); only the oldest-request arbiter combines them.
module sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500,
    parameter int unsigned STUCK_CYCLES    = 1200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_nn,
    input  logic       raw_ns,
    input  logic       raw_th,
    input  logic [1:0] light_nn,
    input  logic [1:0] light_ns,
    input  logic [1:0] light_th,
    output logic       req_nn,
    output logic       req_ns,
    output logic       req_th,
    output logic [2:0] fault,
    output logic [1:0] oldest
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_SERVED = 2'd2
    } req_state_t;

    localparam logic [16:0] DEB_TARGET   = 17'(DEBOUNCE_CYCLES);
    localparam logic [20:0] STUCK_TARGET = 21'(STUCK_CYCLES);
    localparam logic [15:0] AGE_MAX      = 16'hFFFF;

    logic [2:0]  raw;
    logic [1:0]  light [3];

    logic [2:0]  sync1_q, sync2_q;
    logic [2:0]  det_q, det_d;
    logic [2:0]  det_prev_q;
    logic [15:0] dbc_q [3];
    logic [15:0] dbc_d [3];
    logic [20:0] stuck_q [3];
    logic [20:0] stuck_d [3];
    logic [2:0]  fault_q, fault_d;
    logic [15:0] age_q [3];
    logic [15:0] age_d [3];
    logic [1:0]  oldest_q, oldest_d;
    logic [2:0]  req;

    req_state_t  state_q [3];
    req_state_t  state_d [3];

    assign raw      = {raw_th, raw_ns, raw_nn};
    assign light[0] = light_nn;
    assign light[1] = light_ns;
    assign light[2] = light_th;

    // A disagreement run of DEBOUNCE_CYCLES samples flips det; the counter restarts from zero afterwards.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            det_d[c] = det_q[c];
            dbc_d[c] = '0;
            if (sync2_q[c] != det_q[c]) begin
                if ({1'b0, dbc_q[c]} + 17'd1 == DEB_TARGET) begin
                    det_d[c] = sync2_q[c];
                end else begin
                    dbc_d[c] = dbc_q[c] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                S_IDLE: begin
                    if (det_q[c] && !det_prev_q[c]) begin
                        state_d[c] = (light[c] == 2'b10) ? S_SERVED : S_REQ;
                    end
                end
                S_REQ: begin
                    if (light[c] == 2'b10) begin
                        state_d[c] = S_SERVED;
                    end
                end
                S_SERVED: begin
                    // 2'b11 is handled as red alongside 2'b00.
                    if (light[c] == 2'b00 || light[c] == 2'b11) begin
                        state_d[c] = det_q[c] ? S_REQ : S_IDLE;
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            stuck_d[c] = '0;
            fault_d[c] = fault_q[c];
            if (det_q[c]) begin
                stuck_d[c] = (stuck_q[c] == STUCK_TARGET) ? stuck_q[c] : stuck_q[c] + 21'd1;
                if (stuck_q[c] + 21'd1 == STUCK_TARGET) begin
                    fault_d[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            req[c] = (state_q[c] == S_REQ) || fault_q[c];
        end
    end

    // Strict '>' while scanning NN, NS, TH gives the lower channel index the win on equal ages.
    always_comb begin
        logic [15:0] best_age;
        logic        found;
        oldest_d = 2'b00;
        best_age = '0;
        found    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            age_d[c] = req[c] ? ((age_q[c] == AGE_MAX) ? age_q[c] : age_q[c] + 16'd1) : 16'd0;
            if (req[c] && (!found || age_q[c] > best_age)) begin
                found    = 1'b1;
                best_age = age_q[c];
                oldest_d = 2'(c + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            det_q      <= '0;
            det_prev_q <= '0;
            fault_q    <= '0;
            oldest_q   <= 2'b00;
            for (int c = 0; c < 3; c++) begin
                dbc_q[c]   <= '0;
                stuck_q[c] <= '0;
                age_q[c]   <= '0;
                state_q[c] <= S_IDLE;
            end
        end else begin
            sync1_q    <= raw;
            sync2_q    <= sync1_q;
            det_q      <= det_d;
            det_prev_q <= det_q;
            fault_q    <= fault_d;
            oldest_q   <= oldest_d;
            for (int c = 0; c < 3; c++) begin
                dbc_q[c]   <= dbc_d[c];
                stuck_q[c] <= stuck_d[c];
                age_q[c]   <= age_d[c];
                state_q[c] <= state_d[c];
            end
        end
    end

    assign req_nn = req[0];
    assign req_ns = req[1];
    assign req_th = req[2];
    assign fault  = fault_q;
    assign oldest = oldest_q;

endmodule
